// File: rtl/imem_loader.sv
// imem_loader: assembles a big-endian byte stream into 32-bit words and writes them to the instruction memory.
// Defining IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte and drives err on mismatch.

module imem_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] wa,
    output logic [31:0]       wd,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE
    } state_t;

    // State entered once the last word has been written (or straight from IDLE for len=0).
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_FINISH = S_CHECK;
`else
    localparam state_t S_FINISH = S_DONE;
`endif

    state_t            state;
    state_t            state_n;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   len_sat;
    logic [ADDR_W:0]   word_cnt;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        byte_cnt;
    logic [23:0]       shreg;
    logic              xfer;
    logic              last_word;
    logic              in_ready_n;
    logic              we_n;
    logic              busy_n;
    logic              done_n;

    assign xfer      = in_valid && in_ready;
    assign len_sat   = (len > LEN_MAX) ? LEN_MAX : len;
    assign last_word = ((word_cnt + 1'b1) == len_q);

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = (len == '0) ? S_FINISH : S_LOAD;
                end
            end
            S_LOAD: begin
                if (xfer && (byte_cnt == 2'd3)) begin
                    state_n = S_WRITE;
                end
            end
            S_WRITE: begin
                state_n = last_word ? S_FINISH : S_LOAD;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (xfer) begin
                    state_n = S_DONE;
                end
            end
`endif
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state and registered, so none follows an input combinationally.
        in_ready_n = (state_n == S_LOAD);
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (state_n == S_CHECK) begin
            in_ready_n = 1'b1;
        end
`endif
        we_n   = (state_n == S_WRITE);
        busy_n = (state_n != S_IDLE);
        done_n = (state_n == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
            we       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wa       <= '0;
            wd       <= '0;
            len_q    <= '0;
            word_cnt <= '0;
            addr     <= '0;
            byte_cnt <= '0;
        end else begin
            state    <= state_n;
            in_ready <= in_ready_n;
            we       <= we_n;
            busy     <= busy_n;
            done     <= done_n;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len_q    <= len_sat;
                        word_cnt <= '0;
                        addr     <= '0;
                        byte_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    if (xfer) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        // wa/wd only change here, so they hold their last values between pulses.
                        if (byte_cnt == 2'd3) begin
                            wa <= addr;
                            wd <= {shreg, in_data};
                        end
                    end
                end
                S_WRITE: begin
                    addr     <= addr + 1'b1;
                    word_cnt <= word_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Byte assembly: earlier bytes shift toward the MSBs; byte_cnt alone tracks word position.
    always_ff @(posedge clk) begin
        if ((state == S_LOAD) && xfer) begin
            shreg <= {shreg[15:0], in_data};
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] xsum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xsum <= '0;
            err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        xsum <= '0;
                        err  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (xfer) begin
                        xsum <= xsum ^ in_data;
                    end
                end
                S_CHECK: begin
                    if (xfer) begin
                        err <= (in_data != xsum);
                    end
                end
                default: begin
                end
            endcase
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes instruction words into the 64-word instruction memory. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and drives a single-cycle write port at incrementing word addresses. It sits between the host/bench byte source and the instruction memory's write side, and runs before the core leaves reset.

## Interface
Parameters:
- ADDR_W, 6, word-address width; the memory depth is 2^ADDR_W words.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; returns the block to IDLE immediately
- start  in  1  one-cycle request to begin a load; sampled only in IDLE
- len  in  ADDR_W+1  number of words to load; captured when start is taken
- in_valid  in  1  byte-source valid
- in_data  in  8  byte-source data
- in_ready  out  1  loader can take a byte this cycle
- we  out  1  memory write enable (one-cycle pulse per word)
- wa  out  ADDR_W  memory word address
- wd  out  32  memory write data
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at load completion
- err  out  1  checksum mismatch; valid with done, held until the next start

## Operation
- States: IDLE, LOAD, WRITE, CHECK (only when the checksum macro is defined), DONE.
- IDLE: in_ready=0, busy=0. On start=1:
  - Capture len, saturated to 2^ADDR_W.
  - Clear the address counter, byte counter and err.
  - Go to LOAD, or to DONE if len=0.
- start is ignored in every state except IDLE.
- LOAD:
  - in_ready=1. A byte transfers when in_valid && in_ready.
  - The first byte goes to wd[31:24], the second to [23:16], the third to [15:8], the fourth to [7:0].
  - After the fourth byte, go to WRITE.
  - in_valid low means wait with no timeout.
- WRITE (exactly one cycle):
  - we=1, in_ready=0, wa = current address, wd = assembled word.
  - Then increment the address and the word counter.
  - If the word counter equals len, go to DONE (or CHECK when configured). Otherwise go to LOAD.
- Address counter: ADDR_W bits, wraps modulo 2^ADDR_W. The len saturation rule means it never wraps within a single load.
- DONE: done=1 for one cycle, then go to IDLE.
- When we=0, wa and wd hold their last values. Consumers must qualify them with we.
- Reset mid-load: any partial word is discarded and all outputs return to their reset values. Words already written stay in memory.

## Timing
- Reset values: in_ready=0, we=0, wa=0, wd=0, busy=0, done=0, err=0, state IDLE.
- start sampled at edge N → busy=1 and in_ready=1 from cycle N+1.
- The fourth byte of a word accepted at edge K → we=1 during cycle K+1 → in_ready=1 again in cycle K+2.
- Peak throughput: one word per 5 cycles with in_valid held high.
- Last WRITE in cycle W → done=1 in cycle W+1 (no checksum) → busy=0 and IDLE in W+2.
- len=0: start at edge N → done=1 in cycle N+1, and no we pulse occurs.
- All outputs are registered; none depends combinationally on an input.

## Configuration
- Macro `IMEM_LOADER_CHECKSUM_EN`.
- Defined:
  - A running XOR of every data byte is kept.
  - After the last WRITE, the block enters CHECK with in_ready=1 and accepts one checksum byte.
  - The next cycle is DONE, with err = (checksum byte != running XOR).
  - For len=0, CHECK still expects one byte, and the expected value is 0x00.
- Undefined:
  - No CHECK state and no XOR logic.
  - err is tied to 0.
  - The byte stream contains exactly 4·len bytes.

## Test plan
- Reset, then start with len=2 and bytes 0x20,0x08,0x00,0x05,0x8C,0x09,0x00,0x44 sent back-to-back → we pulses with wa=0/wd=0x20080005, then wa=1/wd=0x8C090044. The pulses are 5 cycles apart. done fires one cycle after the second write. busy falls the cycle after done.
- Same stream with in_valid deasserted for 3 cycles after byte 2 → identical writes, each delayed by exactly 3 cycles. No byte is duplicated or lost.
- start with len=0 → done=1 the next cycle and no we pulse. With the checksum macro defined, byte 0x00 is required first and the result is err=0.
- Assert reset two cycles after byte 3 of word 1 → all outputs are 0 immediately. A fresh start with len=1 and bytes 0x11,0x22,0x33,0x44 writes wa=0, wd=0x11223344.
- start asserted while busy, mid-load → ignored: len, the address and the byte position are unchanged.
- `IMEM_LOADER_CHECKSUM_EN` defined, len=1, bytes 0x01,0x02,0x03,0x04: checksum 0x04 → err=0 with done. Checksum 0x05 → err=1, held until the next start.
